// File: rtl/lpf_ser_pkg.sv
// Shared constants and state encoding for the LPF serial programming stage.
package lpf_ser_pkg;

  localparam int unsigned FrameW = 9;
  localparam int unsigned DivW   = 8;
  localparam int unsigned CntW   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

endpackage

// File: rtl/lpf_ser_div.sv
// Half-period counter: pulses tick for one cycle at the end of each CLK_DIV-cycle phase.
module lpf_ser_div
  import lpf_ser_pkg::*;
#(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [DivW-1:0] divcnt_q;

  assign tick = en && (divcnt_q == DivW'(ClkDiv - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divcnt_q <= '0;
    end else if (clr || tick) begin
      divcnt_q <= '0;
    end else if (en) begin
      divcnt_q <= divcnt_q + DivW'(1);
    end
  end

endmodule

// File: rtl/lpf_ser.sv
// Ships {pd, fc} to the analog LPF macro over a 3-wire serial bus whenever it
// differs from the last value sent, plus one forced frame after every reset.
module lpf_ser
  import lpf_ser_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pd,
  input  logic [7:0] fc,
  output logic       ser_clk,
  output logic       ser_data,
  output logic       ser_le,
  output logic       busy
);

  state_e            state_q;
  logic [FrameW-1:0] shadow_q;
  logic [FrameW-1:0] shreg_q;
  logic [CntW-1:0]   bitcnt_q;
  logic              phase_q;
  logic              init_pend_q;
  logic              le_q;
  logic              busy_q;

  logic [FrameW-1:0] frame;
  logic              start;
  logic              tick;

  assign frame = {pd, fc};
  assign start = (state_q == StIdle) && (init_pend_q || (frame != shadow_q));

  lpf_ser_div #(
    .ClkDiv (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (busy_q),
    .tick (tick)
  );

  // shreg is all zeros outside SHIFT (reset, or fully shifted out), so its MSB
  // doubles as the registered data output.
  assign ser_data = shreg_q[FrameW-1];
  assign ser_clk  = phase_q;
  assign ser_le   = le_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      phase_q     <= 1'b0;
      init_pend_q <= 1'b1;
      le_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q     <= frame;
            shadow_q    <= frame;
            init_pend_q <= 1'b0;
            bitcnt_q    <= '0;
            phase_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StShift;
          end
        end
        StShift: begin
          if (tick) begin
            if (!phase_q) begin
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              shreg_q <= {shreg_q[FrameW-2:0], 1'b0};
              if (bitcnt_q == CntW'(FrameW - 1)) begin
                le_q    <= 1'b1;
                state_q <= StLatch;
              end else begin
                bitcnt_q <= bitcnt_q + CntW'(1);
              end
            end
          end
        end
        StLatch: begin
          if (tick) begin
            le_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lpf_ser.sv
// Bench for lpf_ser: two instances (CLK_DIV=2 and 1) share stimulus; a bus monitor
// decodes frames from the serial pins and tasks compare them against a frame model.
module tb_lpf_ser;

  logic       clk;
  logic       rst;
  logic       pd;
  logic [7:0] fc;
  logic [1:0] sclk, sdat, sle, sbusy;

  int vectors    = 0;
  int miscompares = 0;

  lpf_ser #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .rst(rst), .pd(pd), .fc(fc),
    .ser_clk(sclk[0]), .ser_data(sdat[0]), .ser_le(sle[0]), .busy(sbusy[0])
  );

  lpf_ser #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .pd(pd), .fc(fc),
    .ser_clk(sclk[1]), .ser_data(sdat[1]), .ser_le(sle[1]), .busy(sbusy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor state, index 0 = CLK_DIV 2, index 1 = CLK_DIV 1
  logic [8:0] fq0[$];
  logic [8:0] fq1[$];
  logic [8:0] sh[2];
  int         nb[2], hl[2], ll[2], bl[2], lew[2], bw[2];
  logic [1:0] pclk, pdat, ple, pb;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        nb[i] = 0; hl[i] = 0; ll[i] = 0; bl[i] = 0; sh[i] = '0;
        pclk[i] = 1'b0; pdat[i] = 1'b0; ple[i] = 1'b0; pb[i] = 1'b0;
      end else begin
        if (sclk[i]) hl[i]++;
        if (sclk[i] && !pclk[i]) begin
          sh[i] = {sh[i][7:0], sdat[i]};
          nb[i]++;
        end
        if (!sclk[i] && pclk[i]) begin
          vectors++;
          if (hl[i] !== 2 - i) begin
            miscompares++;
            $display("FAIL clk_high_len dut%0d: got %0d cycles, want %0d", i, hl[i], 2 - i);
          end
          hl[i] = 0;
        end
        if (sdat[i] !== pdat[i]) begin
          vectors++;
          if (sclk[i]) begin
            miscompares++;
            $display("FAIL data_stable dut%0d: ser_data changed to %b while ser_clk high",
                     i, sdat[i]);
          end
        end
        if (sle[i]) ll[i]++;
        if (sle[i] && !ple[i]) begin
          vectors++;
          if (nb[i] !== 9) begin
            miscompares++;
            $display("FAIL bit_count dut%0d: got %0d bits before ser_le, want 9", i, nb[i]);
          end
          if (i == 0) fq0.push_back(sh[i]);
          else fq1.push_back(sh[i]);
          nb[i] = 0;
        end
        if (!sle[i] && ple[i]) begin
          lew[i] = ll[i];
          ll[i] = 0;
        end
        if (sbusy[i]) bl[i]++;
        else if (pb[i]) begin
          bw[i] = bl[i];
          bl[i] = 0;
        end
        pclk[i] = sclk[i]; pdat[i] = sdat[i]; ple[i] = sle[i]; pb[i] = sbusy[i];
      end
    end
  end

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    repeat (2) @(posedge clk);
    while (quiet < 4 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (sbusy == 2'b00) quiet++;
      else quiet = 0;
    end
    vectors++;
    if (quiet < 4) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 00", name, sbusy, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pd = 1'b0; fc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (sclk !== 2'b00)  begin miscompares++; $display("FAIL rst_ser_clk: got %b want 00", sclk); end
    if (sdat !== 2'b00)  begin miscompares++; $display("FAIL rst_ser_data: got %b want 00", sdat); end
    if (sle !== 2'b00)   begin miscompares++; $display("FAIL rst_ser_le: got %b want 00", sle); end
    if (sbusy !== 2'b00) begin miscompares++; $display("FAIL rst_busy: got %b want 00", sbusy); end
    rst = 1'b0;
    fq0.delete(); fq1.delete();
    wait_idle("reset_frame");
    vectors += 6;
    if (fq0.size() !== 1) begin
      miscompares++; $display("FAIL rst_frames: got %0d frames want 1", fq0.size());
    end else if (fq0[0] !== 9'h000) begin
      miscompares++; $display("FAIL rst_frame_val: got %h want 000", fq0[0]);
    end
    if (bw[0] !== 38) begin miscompares++; $display("FAIL rst_busy_len: got %0d want 38", bw[0]); end
    if (lew[0] !== 2) begin miscompares++; $display("FAIL rst_le_len: got %0d want 2", lew[0]); end
    if (fq1.size() !== 1) begin
      miscompares++; $display("FAIL rst_frames_div1: got %0d frames want 1", fq1.size());
    end
    if (bw[1] !== 19) begin miscompares++; $display("FAIL rst_busy_len_div1: got %0d want 19", bw[1]); end
    if (lew[1] !== 1) begin miscompares++; $display("FAIL rst_le_len_div1: got %0d want 1", lew[1]); end
    repeat (60) @(posedge clk);
    #1;
    vectors += 2;
    if (fq0.size() !== 1) begin
      miscompares++; $display("FAIL rst_no_refire: got %0d frames want 1", fq0.size());
    end
    if (sbusy !== 2'b00) begin miscompares++; $display("FAIL rst_idle_busy: got %b want 00", sbusy); end
  endtask

  task automatic test_a5;
    fq0.delete(); fq1.delete();
    @(posedge clk); #1;
    pd = 1'b0; fc = 8'hA5;
    wait_idle("a5");
    vectors += 3;
    if (fq0.size() !== 1) begin
      miscompares++; $display("FAIL a5_frames: got %0d want 1", fq0.size());
    end else if (fq0[0] !== 9'h0A5) begin
      miscompares++; $display("FAIL a5_bits: got %b want 010100101", fq0[0]);
    end
    if (fq1.size() !== 1) begin
      miscompares++; $display("FAIL a5_frames_div1: got %0d want 1", fq1.size());
    end else if (fq1[0] !== 9'h0A5) begin
      miscompares++; $display("FAIL a5_bits_div1: got %b want 010100101", fq1[0]);
    end
    if (bw[0] !== 38) begin miscompares++; $display("FAIL a5_busy_len: got %0d want 38", bw[0]); end
  endtask

  task automatic test_overlap;
    fq0.delete(); fq1.delete();
    @(posedge clk); #1;
    fc = 8'h10;
    repeat (10) @(posedge clk); #1;
    fc = 8'h20;
    repeat (10) @(posedge clk); #1;
    fc = 8'h30;
    wait_idle("overlap");
    vectors += 3;
    if (fq0.size() !== 2) begin
      miscompares++; $display("FAIL overlap_frames: got %0d want 2", fq0.size());
    end else if (fq0[0] !== 9'h010 || fq0[1] !== 9'h030) begin
      miscompares++; $display("FAIL overlap_vals: got %h,%h want 010,030", fq0[0], fq0[1]);
    end
    if (fq1.size() == 0) begin
      miscompares++; $display("FAIL overlap_div1_frames: got 0 want >0");
    end else if (fq1[fq1.size()-1] !== 9'h030) begin
      miscompares++; $display("FAIL overlap_div1_last: got %h want 030", fq1[fq1.size()-1]);
    end
    if (bw[0] !== 38) begin miscompares++; $display("FAIL overlap_busy_len: got %0d want 38", bw[0]); end
  endtask

  task automatic test_same;
    int busy_seen = 0;
    fq0.delete(); fq1.delete();
    @(posedge clk); #1;
    fc = 8'h30; pd = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (sbusy != 2'b00) busy_seen++;
    end
    vectors += 2;
    if (busy_seen !== 0) begin miscompares++; $display("FAIL same_busy: got %0d busy cycles want 0", busy_seen); end
    if (fq0.size() + fq1.size() !== 0) begin
      miscompares++; $display("FAIL same_frames: got %0d want 0", fq0.size() + fq1.size());
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    @(posedge clk); #1;
    pd = 1'b1; fc = 8'h5A;
    while (nb[0] < 4 && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #3;
    vectors++;
    if (sbusy[0] !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", sbusy[0]); end
    rst = 1'b1;
    #1;
    vectors++;
    if ({sclk, sdat, sle, sbusy} !== 8'h00) begin
      miscompares++; $display("FAIL mid_async_rst: got %b want 00000000", {sclk, sdat, sle, sbusy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    fq0.delete(); fq1.delete();
    wait_idle("reset_mid");
    vectors += 2;
    if (fq0.size() !== 1 || fq0[0] !== 9'h15A) begin
      miscompares++; $display("FAIL mid_resend: got %0d frames first %h want 1 of 15a",
                              fq0.size(), fq0.size() ? fq0[0] : 9'h0);
    end
    if (fq1.size() !== 1 || fq1[0] !== 9'h15A) begin
      miscompares++; $display("FAIL mid_resend_div1: got %0d frames first %h want 1 of 15a",
                              fq1.size(), fq1.size() ? fq1[0] : 9'h0);
    end
  endtask

  task automatic test_div1;
    fq0.delete(); fq1.delete();
    @(posedge clk); #1;
    pd = 1'b1; fc = 8'hFF;
    wait_idle("div1");
    vectors += 3;
    if (fq1.size() !== 1 || fq1[0] !== 9'h1FF) begin
      miscompares++; $display("FAIL div1_frame: got %0d frames first %h want 1 of 1ff",
                              fq1.size(), fq1.size() ? fq1[0] : 9'h0);
    end
    if (bw[1] !== 19) begin miscompares++; $display("FAIL div1_busy_len: got %0d want 19", bw[1]); end
    if (lew[1] !== 1) begin miscompares++; $display("FAIL div1_le_len: got %0d want 1", lew[1]); end
  endtask

  // Model: latest value is eventually sent; a value equal to the last one sent is skipped.
  task automatic test_random;
    logic [8:0] cur, v1, v2;
    logic [8:0] expq[$];
    int k;
    cur = {pd, fc};
    for (int it = 0; it < 24; it++) begin
      expq.delete(); fq0.delete(); fq1.delete();
      v1 = ($urandom_range(0, 3) == 0) ? cur : 9'($urandom);
      v2 = ($urandom_range(0, 2) == 0) ? v1 : 9'($urandom);
      k  = $urandom_range(3, 15);
      if (v1 != cur) begin expq.push_back(v1); cur = v1; end
      if (v2 != cur) begin expq.push_back(v2); cur = v2; end
      @(posedge clk); #1;
      {pd, fc} = v1;
      repeat (k) @(posedge clk);
      #1;
      {pd, fc} = v2;
      wait_idle("random");
      vectors += 2;
      if (fq0.size() !== expq.size()) begin
        miscompares++; $display("FAIL rand_count it%0d: got %0d frames want %0d", it, fq0.size(), expq.size());
      end else begin
        foreach (expq[j]) begin
          vectors++;
          if (fq0[j] !== expq[j]) begin
            miscompares++; $display("FAIL rand_val it%0d f%0d: got %h want %h", it, j, fq0[j], expq[j]);
          end
        end
      end
      if (fq1.size() !== expq.size()) begin
        miscompares++; $display("FAIL rand_count_div1 it%0d: got %0d frames want %0d", it, fq1.size(), expq.size());
      end else begin
        foreach (expq[j]) begin
          vectors++;
          if (fq1[j] !== expq[j]) begin
            miscompares++; $display("FAIL rand_val_div1 it%0d f%0d: got %h want %h", it, j, fq1[j], expq[j]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; pd = 1'b0; fc = 8'h00;
    test_reset();
    test_a5();
    test_overlap();
    test_same();
    test_reset_mid();
    test_div1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpf_ser.md
# lpf_ser

Serial programming stage for the analog low-pass filter macro, placed directly downstream of the LPF control register block. It watches the registered power-down bit `pd` and 8-bit cutoff code `fc` and, whenever they differ from the last value shipped, serialises a 9-bit frame MSB-first onto a 3-wire bus (`ser_clk`, `ser_data`, `ser_le`). A forced frame after every reset keeps the analog side in step with the digital reset state.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per serial half-period; legal range 1..255.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `pd` input 1: filter power-down request, registered upstream.
- `fc` input 8: filter cutoff code, registered upstream.
- `ser_clk` output 1: serial clock to macro; idles low.
- `ser_data` output 1: serial data, changes only while `ser_clk` low.
- `ser_le` output 1: latch enable, high pulse after last bit.
- `busy` output 1: frame in progress (SHIFT or LATCH).

## Operation
- Frame = {pd, fc[7:0]}, 9 bits, bit 8 (pd) first.
- Registers: `shadow` (9 b, last value sent), `shreg` (9 b), `bitcnt` (0..8), `divcnt` (0..CLK_DIV-1), `phase` (0 low, 1 high), `init_pend` (1 b).
- States: IDLE, SHIFT, LATCH.
- IDLE: if `init_pend` or {pd,fc} != `shadow` -> capture {pd,fc} into `shreg` and `shadow`, clear `init_pend`, clear `bitcnt`/`divcnt`/`phase`, go SHIFT.
- SHIFT: `ser_data` = `shreg[8]`; `ser_clk` = `phase`. `divcnt` counts CLK_DIV cycles per phase. End of low phase -> phase 1. End of high phase -> shift `shreg` left by 1, `bitcnt`+1, phase 0; if `bitcnt` was 8 -> go LATCH.
- LATCH: `ser_clk` 0, `ser_data` 0, `ser_le` 1 for CLK_DIV cycles, then IDLE.
- Input changes during SHIFT/LATCH are ignored; on return to IDLE the compare is re-evaluated, so the latest value is always sent eventually (intermediate values may be skipped).
- All outputs registered; no combinational path from `pd`/`fc` to outputs.

## Timing
- Reset values: `ser_clk` 0, `ser_data` 0, `ser_le` 0, `busy` 0; state IDLE; `shadow` 9'h000; `init_pend` 1.
- First rising `clk` after `rst` deasserts: IDLE sees `init_pend` -> SHIFT; so one frame always follows reset, even with inputs at 0.
- Input change sampled on edge N -> `busy` and first bit on `ser_data` valid after edge N+1.
- Per bit: 2*CLK_DIV cycles; `ser_clk` rises CLK_DIV cycles after `ser_data` settles (setup = hold = CLK_DIV cycles).
- Frame: 18*CLK_DIV cycles SHIFT + CLK_DIV cycles LATCH = 19*CLK_DIV cycles of `busy`.
- Back-to-back: IDLE occupies at least one cycle between frames (`busy` low for >= 1 cycle).
- `rst` asserted mid-frame: all outputs drop to reset values immediately (async); frame aborted; `init_pend` set so a full frame is resent after release.
- CLK_DIV = 1: `ser_clk` toggles every cycle; no special case in logic.

## Structure
- Shared package: frame width constant (9), state encoding (IDLE/SHIFT/LATCH), `CLK_DIV` width constant (8).
- One sub-module: `lpf_ser_div`, the half-period counter producing a one-cycle `tick` at the end of each phase; cleared by the FSM on frame start.
- Top holds the FSM, `shadow`, `shreg`, `bitcnt`, `init_pend`.

## Test plan
- Reset release, pd=0, fc=0, CLK_DIV=2 -> one frame 9'h000, `busy` high 38 cycles, single `ser_le` pulse 2 cycles wide, then idle with no further frames.
- After idle, set pd=0, fc=8'hA5 -> sampled `ser_data` on `ser_clk` rising edges = 0,1,0,1,0,0,1,0,1; `ser_le` pulse after 9th rise.
- Change fc 8'h10 -> 8'h20 -> 8'h30 during one frame -> current frame completes unchanged, exactly one more frame carrying 9'h030; 8'h20 never sent.
- Write same value as `shadow` (fc unchanged) -> no frame, `busy` stays 0.
- Assert `rst` after 4th bit of a frame -> outputs 0 in same cycle; after release full frame with current {pd,fc} resent.
- CLK_DIV=1, pd=1, fc=8'hFF -> `ser_clk` period 2 cycles, data all ones, `busy` 19 cycles.
